// File: rtl/pc_call_stack_if.sv
// Request/status bundle between the fetch-stage controller and pc_call_stack.
interface pc_call_stack_if #(
  parameter int ADDR_W = 8,
  parameter int OFF_W  = 6
);
  logic              hold;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              branch;
  logic [OFF_W-1:0]  branch_off;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  // Controller side: issues requests, observes PC and stack status.
  modport master (
    output hold, jump, jump_addr, branch, branch_off, call, ret,
    input  pc, halted, stack_empty, stack_full, stack_err
  );

  // Program-counter side.
  modport slave (
    input  hold, jump, jump_addr, branch, branch_off, call, ret,
    output pc, halted, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with an integrated return-address stack. Requests are
// resolved by fixed priority (hold > halted > ret > call > jump > branch >
// increment); every output is a register or a decode of registered state.
module pc_call_stack #(
  parameter int          ADDR_W      = 8,
  parameter int          OFF_W       = 6,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned END_ADDR    = 2**ADDR_W - 1
) (
  input  logic           clk,
  input  logic           reset,
  pc_call_stack_if.slave bus
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(END_ADDR);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              err_q, err_nxt;
  logic              push;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              halted;
  logic              empty;
  logic              full;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign off_ext  = ADDR_W'(signed'(bus.branch_off));
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx = IDX_W'(cnt_q);
  assign halted   = (pc_q == END_PC);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);

  // Next-state selection by request priority.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    err_nxt = err_q;
    push    = 1'b0;
    if (!bus.hold && !halted) begin
      if (bus.ret) begin
        if (!empty) begin
          pc_nxt  = stack_mem[top_idx];
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          // Underflow: skip past the bad return and flag it.
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end
      end else if (bus.call) begin
        if (!full) begin
          push    = 1'b1;
          cnt_nxt = cnt_q + CNT_W'(1);
          pc_nxt  = bus.jump_addr;
        end else begin
          // Overflow: drop the call entirely and flag it.
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end
      end else if (bus.jump) begin
        pc_nxt = bus.jump_addr;
      end else if (bus.branch) begin
        pc_nxt = pc_q + off_ext;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  // PC, stack depth and sticky error registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Return-address storage; written only on an accepted call.
  // NOTE: the entries are deliberately not reset -- the depth count alone
  // decides which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.halted      = halted;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.stack_err   = err_q;

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter with an integrated hardware return-address stack for the 8-bit processor datapath. It sits at the front of the fetch stage and drives the instruction-memory address. It supports sequential increment, absolute jump, PC-relative branch, subroutine call/return, pipeline hold and end-of-program halt. All state updates are registered on a single clock edge.

## Interface
- ADDR_W, 8: PC and address width in bits (≥4).
- OFF_W, 6: branch offset width; two's complement, sign-extended to ADDR_W.
- STACK_DEPTH, 4: number of return-address entries (≥1, power of two not required).
- END_ADDR, 2**ADDR_W-1: end-of-program address; the PC parks here.

- clk  in  1  system clock; all updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  freeze: no PC or stack change this cycle.
- jump  in  1  load jump_addr.
- jump_addr  in  ADDR_W  absolute target.
- branch  in  1  taken branch: PC ← PC + sext(branch_off).
- branch_off  in  OFF_W  signed branch displacement.
- call  in  1  push PC+1, then load jump_addr.
- ret  in  1  pop top of stack into PC.
- pc  out  ADDR_W  current instruction address (registered).
- halted  out  1  high while pc == END_ADDR.
- stack_empty  out  1  no entries held.
- stack_full  out  1  STACK_DEPTH entries held.
- stack_err  out  1  sticky: overflow or underflow occurred since reset.

## Operation
- Priority, evaluated each rising edge: reset > hold > halted > ret > call > jump > branch > increment.
- reset: pc=0, stack count=0, stack_err=0. Stack entry contents are don't-care.
- hold: pc, stack and stack_err are unchanged. Request inputs are dropped, not queued.
- halted (pc == END_ADDR): pc stays. Every request except reset is ignored. No stack change and no error.
- ret, stack non-empty: pc ← top entry; count decrements.
- ret, stack empty: underflow. pc ← pc+1 and stack_err ← 1.
- call, stack not full: top ← pc+1 (mod 2^ADDR_W), count increments, pc ← jump_addr.
- call, stack full: overflow. No push, pc ← pc+1, stack_err ← 1.
- jump: pc ← jump_addr.
- branch: pc ← (pc + sext(branch_off)) mod 2^ADDR_W. Wrap-around in both directions is legal and not an error.
- Otherwise: pc ← pc+1. Increment from 2^ADDR_W-1 wraps to 0. This case is only reachable when END_ADDR differs from 2^ADDR_W-1.
- Simultaneous requests resolve by priority only. Lower-priority requests in the same cycle have no effect. For example, call+jump acts as call, and ret+call acts as ret only.
- The stack is LIFO, implemented as a register array plus count (0..STACK_DEPTH).
- stack_empty = (count==0); stack_full = (count==STACK_DEPTH).
- stack_err clears only on reset.

## Timing
- All outputs are registered or are direct decodes of registered state. There are no combinational paths from inputs to outputs.
- Latency: a request sampled at edge N is visible on pc, flags and stack from edge N onward. The new pc appears one cycle after the request is presented.
- Reset values: pc=0, halted=(END_ADDR==0), stack_empty=1, stack_full=0, stack_err=0.
- Reset takes effect on the first edge it is high, mid-operation included. The stack is discarded.
- Back-to-back call/ret on consecutive cycles is supported at full rate. ret immediately after call returns to the call site+1.
- The push and pop pointer updates for a single accepted operation complete in one cycle. There is no read-during-write hazard, because only one stack operation occurs per cycle.

## Test plan
- Reset then 5 idle cycles -> pc = 0,1,2,3,4,5. With reset asserted at pc=5, the next edge gives pc=0 and stack_empty=1.
- pc=10, call jump_addr=40 -> pc=40 and count=1. Three increments, then ret -> pc=11 and stack_empty=1.
- STACK_DEPTH=4: five nested calls -> fifth call leaves pc = previous pc + 1, stack_full=1 and stack_err=1. Four rets then restore the return addresses in reverse order.
- pc=2, branch_off = -4 (6'b111100) -> pc=254 (ADDR_W=8). With pc=250 and branch_off=+10 -> pc=4.
- END_ADDR=20: run to pc=20, then assert jump/call/branch -> pc stays 20 and halted=1. reset -> pc=0 and halted=0.
- hold high for 3 cycles with call asserted -> pc and count unchanged. Same-cycle call+jump -> call executes. ret on empty stack -> pc+1 and stack_err=1, sticky until reset.
